axi4_lite_rr_arbiter: RTL and testbench

Shares one AXI4-Lite slave among `NUM_MSTS` masters so that several register-access engines can reach one register block. The write path (AW/W/B) and the read path (AR/R) are arbitrated independently. Each path grants one master at a time and holds the grant until that transaction's response handshake completes. The arbiter connects to `axi4_lite_if` instances: upstream masters through `slv_port` modports, and the shared downstream slave through the `mst_port` modport.

---
 rtl/axi4_lite_arb_pkg.sv | 14 +
 rtl/axi4_lite_if.sv | 30 +++
 rtl/axi4_lite_rr_arb_core.sv | 77 +++++++
 rtl/axi4_lite_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_axi4_lite_rr_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite round-robin arbiter.
package axi4_lite_arb_pkg;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int gnt_width(input int num_msts);
    return (num_msts > 1) ? $clog2(num_msts) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle; mst_port is the initiator view, slv_port the target view.
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
);
  logic                          awvalid, awready;
  logic [ADDR_BIT_WIDTH-1:0]     awaddr;
  logic [2:0]                    awprot;
  logic                          wvalid, wready;
  logic [DATA_BIT_WIDTH-1:0]     wdata;
  logic [DATA_BIT_WIDTH/8-1:0]   wstrb;
  logic                          bvalid, bready;
  logic [1:0]                    bresp;
  logic                          arvalid, arready;
  logic [ADDR_BIT_WIDTH-1:0]     araddr;
  logic [2:0]                    arprot;
  logic                          rvalid, rready;
  logic [DATA_BIT_WIDTH-1:0]     rdata;
  logic [1:0]                    rresp;

  modport mst_port (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slv_port (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_rr_arb_core.sv
// Grant register, busy flag and winner selection for one arbitrated path.
// AXI4_LITE_RR_ARBITER_FIXED_PRIO_EN selects lowest-index-wins and drops the pointer.
module axi4_lite_rr_arb_core
  import axi4_lite_arb_pkg::*;
#(
  parameter int NUM_MSTS = 2,
  parameter int GNT_W    = gnt_width(NUM_MSTS)
) (
  input  logic                clk,
  input  logic                sync_rst,
  input  logic [NUM_MSTS-1:0] req,
  input  logic                release_pulse,
  output logic [GNT_W-1:0]    gnt,
  output logic                gnt_vld,
  output logic                busy
);

  logic [GNT_W-1:0] gnt_q, gnt_d, win;
  logic             busy_q, busy_d, found;

`ifdef AXI4_LITE_RR_ARBITER_FIXED_PRIO_EN
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = NUM_MSTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        win   = GNT_W'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic [GNT_W-1:0] last_q, last_d;

  // Search starts one past the last served master and wraps.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_MSTS; off++) begin
      idx = int'(last_q) + off;
      if (idx >= NUM_MSTS) idx = idx - NUM_MSTS;
      if (!found && req[idx]) begin
        win   = GNT_W'(idx);
        found = 1'b1;
      end
    end
    last_d = release_pulse ? gnt_q : last_q;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) last_q <= GNT_W'(NUM_MSTS - 1);
    else          last_q <= last_d;
  end
`endif

  always_comb begin
    gnt_vld = found && !busy_q;
    gnt_d   = gnt_vld ? win : gnt_q;
    busy_d  = busy_q ? !release_pulse : found;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      gnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      busy_q <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: rtl/axi4_lite_rr_arbiter.sv
// Shares one AXI4-Lite slave among NUM_MSTS masters; write and read paths arbitrate independently.
// AXI4_LITE_RR_ARBITER_FIXED_PRIO_EN switches both paths from round-robin to fixed priority.
module axi4_lite_rr_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int NUM_MSTS       = 2,
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32
) (
  input  logic          clk,
  input  logic          sync_rst,
  axi4_lite_if.slv_port s_if [NUM_MSTS],
  axi4_lite_if.mst_port m_if
);

  localparam int GNT_W  = gnt_width(NUM_MSTS);
  localparam int STRB_W = DATA_BIT_WIDTH / 8;

  logic [NUM_MSTS-1:0]       aw_req, ar_req, w_sel, r_sel;
  logic                      s_wvalid [NUM_MSTS];
  logic                      s_bready [NUM_MSTS];
  logic                      s_rready [NUM_MSTS];
  logic [ADDR_BIT_WIDTH-1:0] s_awaddr [NUM_MSTS];
  logic [ADDR_BIT_WIDTH-1:0] s_araddr [NUM_MSTS];
  logic [2:0]                s_awprot [NUM_MSTS];
  logic [2:0]                s_arprot [NUM_MSTS];
  logic [DATA_BIT_WIDTH-1:0] s_wdata  [NUM_MSTS];
  logic [STRB_W-1:0]         s_wstrb  [NUM_MSTS];

  logic [GNT_W-1:0] w_gnt, r_gnt;
  logic             w_gnt_vld, r_gnt_vld, w_busy, r_busy, w_release, r_release;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic     aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic     m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;

  axi4_lite_rr_arb_core #(.NUM_MSTS(NUM_MSTS), .GNT_W(GNT_W)) u_wr_core (
    .clk(clk), .sync_rst(sync_rst), .req(aw_req), .release_pulse(w_release),
    .gnt(w_gnt), .gnt_vld(w_gnt_vld), .busy(w_busy)
  );

  axi4_lite_rr_arb_core #(.NUM_MSTS(NUM_MSTS), .GNT_W(GNT_W)) u_rd_core (
    .clk(clk), .sync_rst(sync_rst), .req(ar_req), .release_pulse(r_release),
    .gnt(r_gnt), .gnt_vld(r_gnt_vld), .busy(r_busy)
  );

  for (genvar i = 0; i < NUM_MSTS; i++) begin : g_slv
    assign aw_req[i]   = s_if[i].awvalid;
    assign ar_req[i]   = s_if[i].arvalid;
    assign s_wvalid[i] = s_if[i].wvalid;
    assign s_bready[i] = s_if[i].bready;
    assign s_rready[i] = s_if[i].rready;
    assign s_awaddr[i] = s_if[i].awaddr;
    assign s_araddr[i] = s_if[i].araddr;
    assign s_awprot[i] = s_if[i].awprot;
    assign s_arprot[i] = s_if[i].arprot;
    assign s_wdata[i]  = s_if[i].wdata;
    assign s_wstrb[i]  = s_if[i].wstrb;

    assign w_sel[i] = w_busy && (w_gnt == GNT_W'(i));
    assign r_sel[i] = r_busy && (r_gnt == GNT_W'(i));

    assign s_if[i].awready = (w_state_q == W_ADDR) && w_sel[i] && m_if.awready && !aw_done_q;
    assign s_if[i].wready  = (w_state_q == W_ADDR) && w_sel[i] && m_if.wready && !w_done_q;
    assign s_if[i].bvalid  = (w_state_q == W_RESP) && w_sel[i] && m_if.bvalid;
    assign s_if[i].bresp   = ((w_state_q == W_RESP) && w_sel[i]) ? m_if.bresp : '0;
    assign s_if[i].arready = (r_state_q == R_ADDR) && r_sel[i] && m_if.arready;
    assign s_if[i].rvalid  = (r_state_q == R_DATA) && r_sel[i] && m_if.rvalid;
    assign s_if[i].rdata   = ((r_state_q == R_DATA) && r_sel[i]) ? m_if.rdata : '0;
    assign s_if[i].rresp   = ((r_state_q == R_DATA) && r_sel[i]) ? m_if.rresp : '0;
  end

  assign m_awvalid = (w_state_q == W_ADDR) && aw_req[w_gnt] && !aw_done_q;
  assign m_wvalid  = (w_state_q == W_ADDR) && s_wvalid[w_gnt] && !w_done_q;
  assign m_bready  = (w_state_q == W_RESP) && s_bready[w_gnt];
  assign m_arvalid = (r_state_q == R_ADDR) && ar_req[r_gnt];
  assign m_rready  = (r_state_q == R_DATA) && s_rready[r_gnt];

  assign m_if.awvalid = m_awvalid;
  assign m_if.wvalid  = m_wvalid;
  assign m_if.bready  = m_bready;
  assign m_if.arvalid = m_arvalid;
  assign m_if.rready  = m_rready;
  assign m_if.awaddr  = (w_state_q == W_ADDR) ? s_awaddr[w_gnt] : '0;
  assign m_if.awprot  = (w_state_q == W_ADDR) ? s_awprot[w_gnt] : '0;
  assign m_if.wdata   = (w_state_q == W_ADDR) ? s_wdata[w_gnt]  : '0;
  assign m_if.wstrb   = (w_state_q == W_ADDR) ? s_wstrb[w_gnt]  : '0;
  assign m_if.araddr  = (r_state_q == R_ADDR) ? s_araddr[r_gnt] : '0;
  assign m_if.arprot  = (r_state_q == R_ADDR) ? s_arprot[r_gnt] : '0;

  // AW and W may complete in either order or together; B waits for both.
  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    w_release = 1'b0;
    unique case (w_state_q)
      W_IDLE: if (w_gnt_vld) w_state_d = W_ADDR;
      W_ADDR: begin
        aw_done_d = aw_done_q | (m_awvalid & m_if.awready);
        w_done_d  = w_done_q | (m_wvalid & m_if.wready);
        if (aw_done_d && w_done_d) begin
          w_state_d = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      W_RESP: if (m_if.bvalid && m_bready) begin
        w_state_d = W_IDLE;
        w_release = 1'b1;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_release = 1'b0;
    unique case (r_state_q)
      R_IDLE: if (r_gnt_vld) r_state_d = R_ADDR;
      R_ADDR: if (m_arvalid && m_if.arready) r_state_d = R_DATA;
      R_DATA: if (m_if.rvalid && m_rready) begin
        r_state_d = R_IDLE;
        r_release = 1'b1;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_rr_arbiter.sv
// Directed bench for axi4_lite_rr_arbiter with three masters and a zero-wait slave model.
module tb_axi4_lite_rr_arbiter;
  import axi4_lite_arb_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic sync_rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        mv_awvalid [N];
  logic [31:0] mv_awaddr  [N];
  logic        mv_wvalid  [N];
  logic [31:0] mv_wdata   [N];
  logic        mv_bready  [N];
  logic        mv_arvalid [N];
  logic [31:0] mv_araddr  [N];
  logic        mv_rready  [N];

  logic        o_awready [N];
  logic        o_wready  [N];
  logic        o_bvalid  [N];
  logic [1:0]  o_bresp   [N];
  logic        o_arready [N];
  logic        o_rvalid  [N];
  logic [31:0] o_rdata   [N];
  logic [1:0]  o_rresp   [N];

  axi4_lite_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) s_if [N] ();
  axi4_lite_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) m_if ();

  for (genvar i = 0; i < N; i++) begin : g_mst
    assign s_if[i].awvalid = mv_awvalid[i];
    assign s_if[i].awaddr  = mv_awaddr[i];
    assign s_if[i].awprot  = 3'b000;
    assign s_if[i].wvalid  = mv_wvalid[i];
    assign s_if[i].wdata   = mv_wdata[i];
    assign s_if[i].wstrb   = 4'hF;
    assign s_if[i].bready  = mv_bready[i];
    assign s_if[i].arvalid = mv_arvalid[i];
    assign s_if[i].araddr  = mv_araddr[i];
    assign s_if[i].arprot  = 3'b000;
    assign s_if[i].rready  = mv_rready[i];
    assign o_awready[i] = s_if[i].awready;
    assign o_wready[i]  = s_if[i].wready;
    assign o_bvalid[i]  = s_if[i].bvalid;
    assign o_bresp[i]   = s_if[i].bresp;
    assign o_arready[i] = s_if[i].arready;
    assign o_rvalid[i]  = s_if[i].rvalid;
    assign o_rdata[i]   = s_if[i].rdata;
    assign o_rresp[i]   = s_if[i].rresp;
  end

  axi4_lite_rr_arbiter #(.NUM_MSTS(N), .ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) dut (
    .clk(clk), .sync_rst(sync_rst), .s_if(s_if), .m_if(m_if)
  );

  // Slave model: B one cycle after both AW and W, R one cycle after AR.
  logic        sl_awready, sl_wready, sl_arready;
  logic        sl_bvalid, sl_rvalid, aw_got, w_got;
  logic [1:0]  sl_bresp;
  logic [31:0] sl_awaddr, sl_wdata, sl_rdata;
  int          aw_cnt, w_cnt;
  wire aw_hs = m_if.awvalid & m_if.awready;
  wire w_hs  = m_if.wvalid & m_if.wready;
  wire ar_hs = m_if.arvalid & m_if.arready;

  assign m_if.awready = sl_awready;
  assign m_if.wready  = sl_wready;
  assign m_if.arready = sl_arready;
  assign m_if.bvalid  = sl_bvalid;
  assign m_if.bresp   = sl_bresp;
  assign m_if.rvalid  = sl_rvalid;
  assign m_if.rdata   = sl_rdata;
  assign m_if.rresp   = RESP_OKAY;

  always @(posedge clk) begin
    if (sync_rst) begin
      sl_bvalid <= 1'b0; sl_rvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      sl_bresp <= RESP_OKAY; sl_rdata <= '0; sl_awaddr <= '0; sl_wdata <= '0;
      aw_cnt <= 0; w_cnt <= 0;
    end else begin
      if (aw_hs) begin aw_cnt <= aw_cnt + 1; sl_awaddr <= m_if.awaddr; end
      if (w_hs)  begin w_cnt <= w_cnt + 1;   sl_wdata  <= m_if.wdata;  end
      if (sl_bvalid && m_if.bready) sl_bvalid <= 1'b0;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        sl_bvalid <= 1'b1;
        sl_bresp  <= (aw_hs ? m_if.awaddr[8] : sl_awaddr[8]) ? RESP_SLVERR : RESP_OKAY;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (sl_rvalid && m_if.rready) sl_rvalid <= 1'b0;
      if (ar_hs) begin
        sl_rvalid <= 1'b1;
        sl_rdata  <= (m_if.araddr == 32'h8) ? 32'h1234_5678 : ~m_if.araddr;
      end
    end
  end

  task automatic idle_masters();
    for (int i = 0; i < N; i++) begin
      mv_awvalid[i] = 1'b0; mv_awaddr[i] = '0; mv_wvalid[i] = 1'b0; mv_wdata[i] = '0;
      mv_bready[i] = 1'b0; mv_arvalid[i] = 1'b0; mv_araddr[i] = '0; mv_rready[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_masters();
    sl_awready = 1'b1; sl_wready = 1'b1; sl_arready = 1'b1;
    sync_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sync_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic any_s;
    @(negedge clk);
    sl_awready = 1'b1; sl_wready = 1'b1; sl_arready = 1'b1;
    sync_rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      mv_awvalid[i] = 1'b1; mv_awaddr[i] = 32'h1000 + 32'h100 * i;
      mv_wvalid[i] = 1'b1;  mv_wdata[i] = 32'hA000 + i;  mv_bready[i] = 1'b1;
      mv_arvalid[i] = 1'b1; mv_araddr[i] = 32'h2004 + 32'h100 * i; mv_rready[i] = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready} !== 5'b0 ||
          m_if.awaddr !== '0 || m_if.wdata !== '0 || m_if.wstrb !== '0 || m_if.araddr !== '0) begin
        n_fail++;
        $display("FAIL reset_m_outputs cycle %0d: awv=%b wv=%b br=%b arv=%b rr=%b awaddr=%h wdata=%h araddr=%h, expected all 0",
                 c, m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready, m_if.awaddr, m_if.wdata, m_if.araddr);
      end
      any_s = 1'b0;
      for (int i = 0; i < N; i++)
        any_s = any_s | o_awready[i] | o_wready[i] | o_bvalid[i] | (|o_bresp[i]) | o_arready[i] |
                o_rvalid[i] | (|o_rdata[i]) | (|o_rresp[i]);
      n_tests++;
      if (any_s !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_s_outputs cycle %0d: some s_if output is %b, expected 0", c, any_s);
      end
    end
    sync_rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (m_if.awvalid !== 1'b1 || m_if.awaddr !== 32'h1000 || m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h2004 ||
        o_awready[0] !== 1'b1 || o_awready[1] !== 1'b0 || o_arready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant: awv=%b awaddr=%h arv=%b araddr=%h awready0=%b awready1=%b, expected master 0 (1000/2004)",
               m_if.awvalid, m_if.awaddr, m_if.arvalid, m_if.araddr, o_awready[0], o_awready[1]);
    end
  endtask

  task automatic test_round_robin();
    int got, last_cyc;
    logic [1:0] exp_resp;
    do_reset();
    for (int i = 0; i < N; i++) begin
      mv_awvalid[i] = 1'b1; mv_awaddr[i] = 32'h1000 + 32'h100 * i;
      mv_wvalid[i] = 1'b1;  mv_wdata[i] = 32'hB000 + i; mv_bready[i] = 1'b1;
    end
    got = 0;
    last_cyc = -1;
    for (int c = 0; c < 80 && got < 6; c++) begin
      @(negedge clk);
      if (m_if.bvalid && m_if.bready) begin
        int hot, who;
        hot = 0;
        who = -1;
        for (int i = 0; i < N; i++) if (o_bvalid[i]) begin hot++; who = i; end
        n_tests++;
        if (hot != 1 || who != got % N) begin
          n_fail++;
          $display("FAIL rr_order write %0d: bvalid to master %0d (%0d active), expected master %0d only", got, who, hot, got % N);
        end
        exp_resp = (got % N == 1) ? RESP_SLVERR : RESP_OKAY;
        n_tests++;
        if (who < 0 || o_bresp[who] !== exp_resp) begin
          n_fail++;
          $display("FAIL rr_bresp write %0d: master %0d got bresp %b, expected %b", got, who, (who < 0) ? 2'bxx : o_bresp[who], exp_resp);
        end
        if (last_cyc >= 0) begin
          n_tests++;
          if (c - last_cyc != 3) begin
            n_fail++;
            $display("FAIL rr_back_to_back write %0d: %0d cycles between responses, expected 3", got, c - last_cyc);
          end
        end
        last_cyc = c;
        got++;
        if (got == 6) for (int i = 0; i < N; i++) begin mv_awvalid[i] = 1'b0; mv_wvalid[i] = 1'b0; end
      end
    end
    n_tests++;
    if (got != 6) begin
      n_fail++;
      $display("FAIL rr_timeout: %0d responses seen, expected 6", got);
    end
    @(negedge clk);
    n_tests++;
    if (aw_cnt != 6 || w_cnt != 6) begin
      n_fail++;
      $display("FAIL rr_slave_count: aw=%0d w=%0d, expected 6/6", aw_cnt, w_cnt);
    end
    idle_masters();
  endtask

  task automatic test_w_before_aw();
    do_reset();
    mv_wvalid[1] = 1'b1; mv_wdata[1] = 32'hDEADBEEF; mv_bready[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (m_if.awvalid !== 1'b0 || m_if.wvalid !== 1'b0 || o_wready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL w_only_no_grant cycle %0d: awv=%b wv=%b wready1=%b, expected 0 0 0", c, m_if.awvalid, m_if.wvalid, o_wready[1]);
      end
    end
    mv_awvalid[1] = 1'b1; mv_awaddr[1] = 32'h10;
    @(negedge clk);
    n_tests++;
    if (m_if.awvalid !== 1'b1 || m_if.wvalid !== 1'b1 || m_if.awaddr !== 32'h10 || m_if.wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL w_before_aw_fwd: awv=%b wv=%b awaddr=%h wdata=%h, expected 1 1 10 deadbeef",
               m_if.awvalid, m_if.wvalid, m_if.awaddr, m_if.wdata);
    end
    @(negedge clk);
    mv_awvalid[1] = 1'b0; mv_wvalid[1] = 1'b0;
    n_tests++;
    if (o_bvalid[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL w_before_aw_bvalid: bvalid1=%b, expected 1", o_bvalid[1]);
    end
    @(negedge clk);
    n_tests++;
    if (aw_cnt != 1 || w_cnt != 1 || sl_awaddr !== 32'h10 || sl_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL w_before_aw_slave: aw=%0d w=%0d addr=%h data=%h, expected 1 1 10 deadbeef", aw_cnt, w_cnt, sl_awaddr, sl_wdata);
    end
    idle_masters();
  endtask

  task automatic test_concurrent();
    do_reset();
    mv_awvalid[0] = 1'b1; mv_awaddr[0] = 32'h4; mv_wvalid[0] = 1'b1; mv_wdata[0] = 32'hA5A5_0004; mv_bready[0] = 1'b1;
    mv_arvalid[1] = 1'b1; mv_araddr[1] = 32'h8; mv_rready[1] = 1'b1;
    @(negedge clk);
    n_tests++;
    if (m_if.awvalid !== 1'b1 || m_if.awaddr !== 32'h4 || m_if.arvalid !== 1'b1 || m_if.araddr !== 32'h8) begin
      n_fail++;
      $display("FAIL concurrent_fwd: awv=%b awaddr=%h arv=%b araddr=%h, expected 1 4 1 8",
               m_if.awvalid, m_if.awaddr, m_if.arvalid, m_if.araddr);
    end
    @(negedge clk);
    mv_awvalid[0] = 1'b0; mv_wvalid[0] = 1'b0; mv_arvalid[1] = 1'b0;
    n_tests++;
    if (o_rvalid[1] !== 1'b1 || o_rdata[1] !== 32'h1234_5678 || o_rresp[1] !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL concurrent_rdata: rvalid1=%b rdata1=%h rresp1=%b, expected 1 12345678 00", o_rvalid[1], o_rdata[1], o_rresp[1]);
    end
    n_tests++;
    if (o_rvalid[0] !== 1'b0 || o_rdata[0] !== '0 || o_rvalid[2] !== 1'b0 || o_rdata[2] !== '0) begin
      n_fail++;
      $display("FAIL concurrent_r_isolation: rvalid0=%b rdata0=%h rvalid2=%b rdata2=%h, expected 0", o_rvalid[0], o_rdata[0], o_rvalid[2], o_rdata[2]);
    end
    n_tests++;
    if (o_bvalid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL concurrent_bvalid: bvalid0=%b, expected 1", o_bvalid[0]);
    end
    @(negedge clk);
    idle_masters();
  endtask

  task automatic test_backpressure();
    do_reset();
    sl_awready = 1'b0;
    mv_awvalid[0] = 1'b1; mv_awaddr[0] = 32'h30; mv_wvalid[0] = 1'b1; mv_wdata[0] = 32'h3030;
    mv_awvalid[2] = 1'b1; mv_awaddr[2] = 32'h40; mv_wvalid[2] = 1'b1; mv_wdata[2] = 32'h4040;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (m_if.awvalid !== 1'b1 || m_if.awaddr !== 32'h30 || o_awready[0] !== 1'b0 || o_awready[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: awv=%b awaddr=%h awready0=%b awready2=%b, expected 1 30 0 0",
                 k, m_if.awvalid, m_if.awaddr, o_awready[0], o_awready[2]);
      end
      if (k >= 2) begin
        n_tests++;
        if (m_if.wvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_w_done cycle %0d: m wvalid=%b, expected 0 after W handshake", k, m_if.wvalid);
        end
      end
    end
    sl_awready = 1'b1;
    @(negedge clk);
    mv_awvalid[0] = 1'b0; mv_wvalid[0] = 1'b0;
    n_tests++;
    if (o_bvalid[0] !== 1'b1 || m_if.bready !== 1'b0 || o_awready[2] !== 1'b0 || aw_cnt != 1) begin
      n_fail++;
      $display("FAIL bp_resp: bvalid0=%b bready=%b awready2=%b aw_cnt=%0d, expected 1 0 0 1", o_bvalid[0], m_if.bready, o_awready[2], aw_cnt);
    end
    @(negedge clk);
    n_tests++;
    if (o_bvalid[0] !== 1'b1 || aw_cnt != 1 || m_if.awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall: bvalid0=%b aw_cnt=%0d awv=%b, expected 1 1 0", o_bvalid[0], aw_cnt, m_if.awvalid);
    end
    mv_bready[0] = 1'b1;
    @(negedge clk);
    mv_bready[0] = 1'b0;
    n_tests++;
    if (m_if.awvalid !== 1'b0 || o_bvalid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_idle: awv=%b bvalid0=%b, expected 0 0", m_if.awvalid, o_bvalid[0]);
    end
    @(negedge clk);
    n_tests++;
    if (m_if.awvalid !== 1'b1 || m_if.awaddr !== 32'h40) begin
      n_fail++;
      $display("FAIL bp_next_grant: awv=%b awaddr=%h, expected 1 40", m_if.awvalid, m_if.awaddr);
    end
    idle_masters();
  endtask

  task automatic test_reset_mid_txn();
    logic any_s;
    do_reset();
    mv_arvalid[0] = 1'b1; mv_araddr[0] = 32'h8;
    mv_awvalid[1] = 1'b1; mv_awaddr[1] = 32'h20; mv_wvalid[1] = 1'b1; mv_wdata[1] = 32'h2020;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (o_rvalid[0] !== 1'b1 || o_bvalid[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rst_setup: rvalid0=%b bvalid1=%b, expected 1 1", o_rvalid[0], o_bvalid[1]);
    end
    sync_rst = 1'b1;
    mv_rready[0] = 1'b1; mv_bready[1] = 1'b1;
    @(negedge clk);
    any_s = 1'b0;
    for (int i = 0; i < N; i++)
      any_s = any_s | o_awready[i] | o_wready[i] | o_bvalid[i] | o_arready[i] | o_rvalid[i];
    n_tests++;
    if ({m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready} !== 5'b0 || any_s !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_idle: m awv/wv/br/arv/rr=%b%b%b%b%b s_any=%b, expected all 0",
               m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready, any_s);
    end
    sync_rst = 1'b0;
    idle_masters();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_masters();
    sl_awready = 1'b1; sl_wready = 1'b1; sl_arready = 1'b1;
    test_reset();
    test_round_robin();
    test_w_before_aw();
    test_concurrent();
    test_backpressure();
    test_reset_mid_txn();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
